// File: rtl/vending_machine.sv
// -----------------------------------------------------------------------------
// vending_machine
//
// Coin-accepting controller for a 15-cent can dispenser. It sits between the
// coin-validator front end and the dispense solenoid driver. The controller
// accepts 5c and 10c coin strobes and keeps the running credit in a
// three-state FSM. It pulses zcan for one cycle each time the credit reaches
// 15c.
//
// Ports
//   _clk  in   1  system clock; all state changes on the rising edge
//   _rst  in   1  asynchronous, active-high reset (s -> S0, zcan -> 0)
//   c5    in   1  5-cent coin present this cycle (level, sampled at posedge)
//   c10   in   1  10-cent coin present this cycle (level, sampled at posedge)
//   zcan  out  1  registered dispense pulse, high one cycle per vend
//   s     out  2  registered credit state: 00=0c, 01=5c, 10=10c
//
// Build option
//   VM_CARRY_EN  When defined, a vend keeps the credit left over from the
//                coins (5c -> S5, 10c -> S10). When undefined, every vend
//                returns to S0 and the excess is forfeited.
//
// Both outputs come straight from flops, so there is no combinational path
// from the coin inputs to the outputs. Results appear one cycle after the
// coin is sampled.
// -----------------------------------------------------------------------------
module vending_machine (
  input  logic       _clk,
  input  logic       _rst,
  input  logic       c5,
  input  logic       c10,
  output logic       zcan,
  output logic [1:0] s
);

  typedef enum logic [1:0] {
    S0    = 2'b00,   // 0c credit
    S5    = 2'b01,   // 5c credit
    S10   = 2'b10,   // 10c credit
    S_ILL = 2'b11    // unreachable encoding, recovered to S0
  } state_t;

  // Landing state after a vend that overshoots 15c by 5c or by 10c.
`ifdef VM_CARRY_EN
  localparam state_t EXCESS5_STATE  = S5;
  localparam state_t EXCESS10_STATE = S10;
`else
  localparam state_t EXCESS5_STATE  = S0;
  localparam state_t EXCESS10_STATE = S0;
`endif

  state_t state_reg;
  logic   zcan_reg;

  // The single FSM process below also drives the registered dispense pulse.
  // zcan_reg is assigned on every clock edge, so the pulse falls on the next
  // edge unless that edge completes another vend.
  always_ff @(posedge _clk or posedge _rst) begin
    if (_rst) begin
      state_reg <= S0;
      zcan_reg  <= 1'b0;
    end else begin
      zcan_reg <= 1'b0;
      case (state_reg)
        S0: begin
          case ({c10, c5})
            2'b01: state_reg <= S5;
            2'b10: state_reg <= S10;
            2'b11: begin                // exactly 15c in a single cycle
              zcan_reg  <= 1'b1;
              state_reg <= S0;
            end
            default: state_reg <= S0;
          endcase
        end

        S5: begin
          case ({c10, c5})
            2'b01: state_reg <= S10;
            2'b10: begin                // 5 + 10 = 15, no excess
              zcan_reg  <= 1'b1;
              state_reg <= S0;
            end
            2'b11: begin                // 5 + 15 = 20, 5c excess
              zcan_reg  <= 1'b1;
              state_reg <= EXCESS5_STATE;
            end
            default: state_reg <= S5;
          endcase
        end

        S10: begin
          case ({c10, c5})
            2'b01: begin                // 10 + 5 = 15, no excess
              zcan_reg  <= 1'b1;
              state_reg <= S0;
            end
            2'b10: begin                // 10 + 10 = 20, 5c excess
              zcan_reg  <= 1'b1;
              state_reg <= EXCESS5_STATE;
            end
            2'b11: begin                // 10 + 15 = 25, 10c excess
              zcan_reg  <= 1'b1;
              state_reg <= EXCESS10_STATE;
            end
            default: state_reg <= S10;
          endcase
        end

        // Recover from the illegal encoding. Coins sampled on this edge are
        // dropped because the credit they would add to is not trustworthy.
        default: begin
          state_reg <= S0;
        end
      endcase
    end
  end

  assign zcan = zcan_reg;
  assign s    = state_reg;

endmodule

// File: tb/tb_vending_machine.sv
module tb_vending_machine;

  logic       clk;
  logic       rst;
  logic       c5;
  logic       c10;
  logic       zcan;
  logic [1:0] s;

  int checks = 0;
  int passes = 0;
  int credit = 0;                 // reference model: credit in cents
  logic [2:0] exp_q[$];           // expected {zcan, s} for each upcoming edge
  bit stim_done = 0;

  vending_machine dut (
    ._clk (clk),
    ._rst (rst),
    .c5   (c5),
    .c10  (c10),
    .zcan (zcan),
    .s    (s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got zcan=%0b s=%02b, want zcan=%0b s=%02b",
                  name, act[2], act[1:0], exp[2], exp[1:0]);
  endtask

  // The reference model works in cents. Credit rises by the coin value. At
  // 15c or more the machine vends and keeps either nothing or the overshoot.
  task automatic apply(input logic v5, input logic v10);
    int total;
    logic vend;
    @(negedge clk);
    c5  = v5;
    c10 = v10;
    total = credit + (v5 ? 5 : 0) + (v10 ? 10 : 0);
    vend  = (total >= 15);
    if (vend) begin
`ifdef VM_CARRY_EN
      credit = total - 15;
`else
      credit = 0;
`endif
    end else begin
      credit = total;
    end
    exp_q.push_back({vend, 2'(credit / 5)});
    $display("txn c5=%0b c10=%0b -> expect zcan=%0b credit=%0dc", v5, v10, vend, credit);
  endtask

  // Monitor: every edge yields an output. Compare it with the oldest entry
  // in the expectation queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("edge", {zcan, s}, exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1;
    c5  = 1'b0;
    c10 = 1'b0;
    #1;
    check("reset_state", {zcan, s}, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Three 5c coins
    apply(1, 0); apply(1, 0); apply(1, 0); apply(0, 0);
    // 10c then 5c, then 5c then 10c
    apply(0, 1); apply(1, 0);
    apply(1, 0); apply(0, 1);
    // Continuous 10c for four edges, then idle
    apply(0, 1); apply(0, 1); apply(0, 1); apply(0, 1);
    apply(0, 0); apply(0, 0);
    // Both coins at once from an empty credit, then idle
    credit = credit;            // model carries on from the current credit
    apply(1, 1); apply(0, 0); apply(0, 0);
    // Both coins from 5c and from 10c (excess cases)
    apply(1, 0); apply(1, 1);
    apply(0, 1); apply(1, 1); apply(0, 0);

    // Bring the machine to 10c, then reset asynchronously mid-cycle while
    // coins are present.
    apply(0, 0);
    while (credit != 0) apply(1, 0);
    apply(0, 1);
    @(posedge clk);
    #2;
    c5  = 1'b1;
    c10 = 1'b1;
    rst = 1'b1;
    #1;
    check("async_reset", {zcan, s}, 3'b000);
    @(posedge clk);
    #1;
    check("reset_hold", {zcan, s}, 3'b000);
    @(negedge clk);
    rst    = 1'b0;
    c5     = 1'b0;
    c10    = 1'b0;
    credit = 0;

    // Randomized coins, with idle cycles mixed in
    for (int i = 0; i < 300; i++) begin
      logic [1:0] r;
      r = 2'($urandom_range(0, 3));
      apply(r[0], r[1]);
    end
    apply(0, 0);

    // Drain the queue within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    stim_done = 1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Global time limit so the bench can never hang
  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL timeout: stimulus not done, want done");
      $fatal(1, "timeout");
    end
  end

endmodule
